// File: rtl/activation_pipe.sv
`default_nettype none
// ============================================================================
// Module   : activation_pipe
// Purpose  : Two-stage pipelined activation unit. Applies one of four
//            run-time-selectable activations (threshold ReLU, ReLU, clipped
//            ReLU, leaky ReLU) to LANES signed fixed-point values per beat,
//            with a valid/ready handshake and full backpressure.
// Ports    : clk, rst_n         - clock, asynchronous active-low reset
//            i_cfg_we           - load i_cfg_mode/i_cfg_thresh/i_cfg_clip
//            i_cfg_mode         - 0=thresh ReLU, 1=ReLU, 2=clipped, 3=leaky
//            i_cfg_thresh       - signed threshold (mode 0)
//            i_cfg_clip         - signed upper clip (mode 2)
//            i_in_valid/o_in_ready/i_in_data     - input beat handshake
//            o_out_valid/i_out_ready/o_out_data  - output beat handshake
//            o_zero_count       - zero-lane counter (ACT_ZERO_STATS_EN only)
// Options  : `define ACT_ZERO_STATS_EN adds the saturating 32-bit counter of
//            zero-valued output lanes and its o_zero_count port.
// Revision : 1.0 - initial release
// ============================================================================
module activation_pipe #(
    parameter int WIDTH      = 16,
    parameter int FRAC_BITS  = 8,
    parameter int LANES      = 4,
    parameter int LEAK_SHIFT = 3
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   i_cfg_we,
    input  logic [1:0]             i_cfg_mode,
    input  logic [WIDTH-1:0]       i_cfg_thresh,
    input  logic [WIDTH-1:0]       i_cfg_clip,
    input  logic                   i_in_valid,
    output logic                   o_in_ready,
    input  logic [LANES*WIDTH-1:0] i_in_data,
    output logic                   o_out_valid,
    input  logic                   i_out_ready,
    output logic [LANES*WIDTH-1:0] o_out_data
`ifdef ACT_ZERO_STATS_EN
    ,
    output logic [31:0]            o_zero_count
`endif
);

    localparam logic [1:0] c_MODE_TRELU = 2'd0;
    localparam logic [1:0] c_MODE_RELU  = 2'd1;
    localparam logic [1:0] c_MODE_CLIP  = 2'd2;
    localparam logic [1:0] c_MODE_LEAKY = 2'd3;

    localparam logic [WIDTH-1:0] c_THRESH_RST = {{(WIDTH-1){1'b0}}, 1'b1} << FRAC_BITS;
    localparam logic [WIDTH-1:0] c_CLIP_RST   = {1'b0, {(WIDTH-1){1'b1}}};

    // Configuration registers
    logic [1:0]             r_mode;
    logic [WIDTH-1:0]       r_thresh;
    logic [WIDTH-1:0]       r_clip;

    // Stage 1: data, per-lane compare flags and config snapshot
    logic                   r_s1_valid;
    logic [LANES*WIDTH-1:0] r_s1_data;
    logic [LANES-1:0]       r_s1_neg;
    logic [LANES-1:0]       r_s1_le_th;
    logic [LANES-1:0]       r_s1_gt_clip;
    logic [1:0]             r_s1_mode;
    logic [WIDTH-1:0]       r_s1_clip;

    // Stage 2 (output registers)
    logic                   r_out_valid;
    logic [LANES*WIDTH-1:0] r_out_data;

    logic                   w_s2_adv;
    logic                   w_s1_adv;
    logic [LANES-1:0]       w_neg;
    logic [LANES-1:0]       w_le_th;
    logic [LANES-1:0]       w_gt_clip;
    logic [LANES*WIDTH-1:0] w_res;

    // Each stage moves when its downstream slot is empty or draining.
    assign w_s2_adv   = !r_out_valid || i_out_ready;
    assign w_s1_adv   = !r_s1_valid || w_s2_adv;
    assign o_in_ready = w_s1_adv;

    assign o_out_valid = r_out_valid;
    assign o_out_data  = r_out_data;

    generate
        for (genvar i = 0; i < LANES; i++) begin : g_lane
            logic signed [WIDTH-1:0] w_x;
            logic signed [WIDTH-1:0] w_s1_x;
            logic signed [WIDTH-1:0] w_shr;
            logic        [WIDTH-1:0] w_lane_res;

            // Compares use the live config so a beat sees the settings
            // registered at the moment it is accepted.
            assign w_x          = $signed(i_in_data[i*WIDTH +: WIDTH]);
            assign w_neg[i]     = w_x[WIDTH-1];
            assign w_le_th[i]   = w_x <= $signed(r_thresh);
            assign w_gt_clip[i] = w_x > $signed(r_clip);

            assign w_s1_x = $signed(r_s1_data[i*WIDTH +: WIDTH]);
            assign w_shr  = w_s1_x >>> LEAK_SHIFT;

            always_comb begin
                w_lane_res = w_s1_x;
                case (r_s1_mode)
                    c_MODE_TRELU: if (r_s1_neg[i] || r_s1_le_th[i]) w_lane_res = '0;
                    c_MODE_RELU:  if (r_s1_neg[i]) w_lane_res = '0;
                    c_MODE_CLIP: begin
                        // Negative test wins, so a negative clip still
                        // zeroes negative inputs.
                        if (r_s1_neg[i])          w_lane_res = '0;
                        else if (r_s1_gt_clip[i]) w_lane_res = r_s1_clip;
                    end
                    c_MODE_LEAKY: if (r_s1_neg[i]) w_lane_res = w_shr;
                    default:      w_lane_res = w_s1_x;
                endcase
            end

            assign w_res[i*WIDTH +: WIDTH] = w_lane_res;
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mode   <= c_MODE_TRELU;
            r_thresh <= c_THRESH_RST;
            r_clip   <= c_CLIP_RST;
        end else if (i_cfg_we) begin
            r_mode   <= i_cfg_mode;
            r_thresh <= i_cfg_thresh;
            r_clip   <= i_cfg_clip;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_valid   <= 1'b0;
            r_s1_data    <= '0;
            r_s1_neg     <= '0;
            r_s1_le_th   <= '0;
            r_s1_gt_clip <= '0;
            r_s1_mode    <= c_MODE_TRELU;
            r_s1_clip    <= c_CLIP_RST;
        end else if (w_s1_adv) begin
            r_s1_valid <= i_in_valid;
            if (i_in_valid) begin
                r_s1_data    <= i_in_data;
                r_s1_neg     <= w_neg;
                r_s1_le_th   <= w_le_th;
                r_s1_gt_clip <= w_gt_clip;
                r_s1_mode    <= r_mode;
                r_s1_clip    <= r_clip;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
        end else if (w_s2_adv) begin
            r_out_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_out_data <= w_res;
            end
        end
    end

`ifdef ACT_ZERO_STATS_EN
    localparam int c_ZW = $clog2(LANES + 1);

    logic [31:0]     r_zero_count;
    logic [c_ZW-1:0] w_zero_lanes;
    logic [32:0]     w_zc_sum;

    always_comb begin
        w_zero_lanes = '0;
        for (int k = 0; k < LANES; k++) begin
            if (r_out_data[k*WIDTH +: WIDTH] == '0) begin
                w_zero_lanes = w_zero_lanes + c_ZW'(1);
            end
        end
    end

    assign w_zc_sum = {1'b0, r_zero_count} + 33'(w_zero_lanes);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_zero_count <= '0;
        end else if (i_cfg_we) begin
            r_zero_count <= '0;
        end else if (r_out_valid && i_out_ready) begin
            r_zero_count <= w_zc_sum[32] ? 32'hFFFF_FFFF : w_zc_sum[31:0];
        end
    end

    assign o_zero_count = r_zero_count;
`endif

endmodule
`default_nettype wire

// File: doc/activation_pipe.md
Name: activation_pipe

Overview:
- Parametrised, pipelined successor to the single-lane combinational activation stage.
- Applies one of four run-time-selectable activations to LANES signed fixed-point values per beat.
- Sits between the neuron MAC/accumulator output and the next layer's input buffer.
- valid/ready handshake with full backpressure; 2-stage registered pipeline.

Parameters:
- WIDTH, 16, bits per lane value, two's complement, FRAC_BITS fractional bits.
- FRAC_BITS, 8, fractional bits; sets the default threshold of 1.0.
- LANES, 4, number of parallel values per beat.
- LEAK_SHIFT, 3, arithmetic right shift applied to negatives in leaky mode (slope 1/8).

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- cfg_we  in  1  load the cfg_* values on this cycle.
- cfg_mode  in  2  0=threshold ReLU, 1=ReLU, 2=clipped ReLU, 3=leaky ReLU.
- cfg_thresh  in  WIDTH  signed threshold for mode 0.
- cfg_clip  in  WIDTH  signed upper clip for mode 2.
- in_valid  in  1  input beat valid.
- in_ready  out  1  block accepts a beat this cycle.
- in_data  in  LANES*WIDTH  lane i at [i*WIDTH +: WIDTH].
- out_valid  out  1  output beat valid.
- out_ready  in  1  downstream accepts.
- out_data  out  LANES*WIDTH  activated lanes, same packing as in_data.

Behaviour:
- Reset:
  - out_valid=0, out_data=0, and both stage valids cleared.
  - mode=0, thresh=1<<FRAC_BITS (1.0), clip=largest positive value (0111..1).
  - in_ready=1 once rst_n is high. Reset may assert mid-stream; in-flight beats are discarded.
- Config:
  - Registered on cfg_we. A beat captures the mode, threshold and clip that are registered when it enters stage 1, and carries that snapshot down the pipe.
  - If cfg_we and an input handshake occur in the same cycle, the beat uses the old config.
- Pipeline:
  - Stage 1 registers the data and the per-lane compare flags (negative, <=thresh, >clip).
  - Stage 2 registers the result into out_data.
- Latency is 2 cycles from the in handshake to out_valid, with out_ready held high. Throughput is 1 beat/cycle.
- Stall rules:
  - s2_adv = !out_valid | out_ready
  - s1_adv = !s1_valid | s2_adv
  - in_ready = s1_adv (combinational, no combinational in_valid->in_ready path)
  - While out_valid is high and out_ready is low, out_data and out_valid are held stable.
- Per-lane function (x signed):
  - mode 0: out = (x<0 or x<=thresh) ? 0 : x.
  - mode 1: out = x<0 ? 0 : x.
  - mode 2: out = x<0 ? 0 : (x>clip ? clip : x).
  - mode 3: out = x<0 ? (x>>>LEAK_SHIFT) : x.
- Arithmetic rules:
  - All compares are signed WIDTH-bit.
  - No overflow is possible.
  - Leaky mode on the most negative value gives -(2^(WIDTH-1-LEAK_SHIFT)).
- A negative clip in mode 2 yields clip for x>clip and 0 for x<0; the configuration is legal and not checked.
- Lanes are independent. No lane may depend on another.

Optional Feature:
- Macro ACT_ZERO_STATS_EN.
- Defined:
  - Extra output port zero_count, 32 bits.
  - Counts output lanes equal to 0 on each out handshake (out_valid & out_ready), adding 0..LANES per cycle.
  - Saturates at 2^32-1.
  - Cleared by reset and by cfg_we.
- Undefined: the port and counter are absent; all other behaviour is identical.

Test Plan:
1. Default config, LANES=4, in = {0x0101, 0x0100, 0xFF00, 0x0000} -> out two cycles later = {0x0101, 0, 0, 0}.
2. Mode 1, in = {0x7FFF, 0x0001, 0x8000, 0x0050} -> {0x7FFF, 0x0001, 0, 0x0050}.
3. Mode 2, clip=0x0200, in = {0x0300, 0x0200, 0x01FF, 0xFFFF} -> {0x0200, 0x0200, 0x01FF, 0}.
4. Mode 3, LEAK_SHIFT=3, in = {0xFF00, 0x8000, 0x0010, 0xFFF8} -> {0xFFE0, 0xF000, 0x0010, 0xFFFF}.
5. Backpressure:
   - Stimulus: stream 6 beats with out_ready low for cycles 3-6.
   - Required: in_ready deasserts after 2 beats are buffered, out_data is stable during the stall, and all 6 beats emerge in order with none lost or duplicated.
6. Reset and config interaction:
   - Assert rst_n low with 2 beats in flight -> out_valid=0 immediately and config returns to defaults.
   - With ACT_ZERO_STATS_EN, test 1 gives zero_count=3, and cfg_we clears it to 0.
